// File: rtl/stw_pkg.sv
// STW scheduler shared types: FSM states, the self-test vector table,
// and the expected-result function.
package stw_pkg;

  typedef enum logic [2:0] {
    IDLE, REQ, LOAD, START, WAIT, CHECK, DONE
  } stw_state_t;

  localparam int STW_NUM_VEC = 4;

  typedef struct packed {
    logic [15:0] op1;
    logic [15:0] op2;
    logic [15:0] add;
  } stw_vec_t;

  function automatic stw_vec_t stw_vec(input logic [1:0] idx);
    stw_vec_t v;
    case (idx)
      2'd0:    v = '{16'd3,    16'd5,    16'd7};
      2'd1:    v = '{16'hFFFF, 16'hFFFF, 16'h0001};
      2'd2:    v = '{16'hAAAA, 16'h0001, 16'h5555};
      default: v = '{16'h0100, 16'h0100, 16'h1234};
    endcase
    return v;
  endfunction

  // Full 32-bit result; callers keep the low WORD_SIZE bits.
  function automatic logic [31:0] stw_expect(
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [31:0] c
  );
    return a * b + c;
  endfunction

endpackage

// File: rtl/stw_vector_rom.sv
// Combinational STW vector lookup: index -> op1/op2/add/expected.
// Ports: idx in; op1, op2, add, expected out (WORD_SIZE each).
import stw_pkg::*;

module stw_vector_rom #(
  parameter int WORD_SIZE = 16
) (
  input  logic [1:0]           idx,
  output logic [WORD_SIZE-1:0] op1,
  output logic [WORD_SIZE-1:0] op2,
  output logic [WORD_SIZE-1:0] add,
  output logic [WORD_SIZE-1:0] expected
);

  stw_vec_t    v;
  logic [31:0] full;

  assign v    = stw_vec(idx);
  assign full = stw_expect(32'(v.op1), 32'(v.op2), 32'(v.add));

  assign op1      = WORD_SIZE'(v.op1);
  assign op2      = WORD_SIZE'(v.op2);
  assign add      = WORD_SIZE'(v.add);
  assign expected = WORD_SIZE'(full);

endmodule

// File: rtl/stw_scheduler.sv
// Schedules self-test word runs over all PEs and keeps a sticky fault map.
// Ports: clk/rst; test_req; stw_req/stw_grant slot handshake; broadcast
// load_en/ops/expected/start; per-PE complete/result in; fault_clear;
// fault_map/any_fault; run_done pulse; saturating run_count.
import stw_pkg::*;

module stw_scheduler #(
  parameter int WORD_SIZE   = 16,
  parameter int NUM_PE      = 16,
  parameter int NUM_VECTORS = 4,
  parameter int INTERVAL    = 1024,
  parameter int TIMEOUT     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 test_req,
  output logic                 stw_req,
  input  logic                 stw_grant,
  output logic                 stw_load_en,
  output logic [WORD_SIZE-1:0] stw_mult_op1,
  output logic [WORD_SIZE-1:0] stw_mult_op2,
  output logic [WORD_SIZE-1:0] stw_add_op,
  output logic [WORD_SIZE-1:0] stw_expected,
  output logic                 stw_start,
  input  logic [NUM_PE-1:0]    stw_complete_in,
  input  logic [NUM_PE-1:0]    stw_result_in,
  input  logic                 fault_clear,
  output logic [NUM_PE-1:0]    fault_map,
  output logic                 any_fault,
  output logic                 run_done,
  output logic [15:0]          run_count
);

  localparam logic [1:0]  LAST_VEC = 2'(NUM_VECTORS - 1);
  localparam logic [15:0] WAIT_MAX = 16'(TIMEOUT - 1);
  localparam logic [31:0] IVL_MAX  = 32'(INTERVAL - 1);

  stw_state_t          state;
  stw_state_t          state_nxt;
  logic                pending;
  logic [31:0]         ivl_cnt;
  logic [1:0]          vec_idx;
  logic [15:0]         wait_cnt;
  logic                timeout_q;
  logic [NUM_PE-1:0]   run_fail;

  logic                in_run;
  logic                grant_lost;
  logic                all_done;
  logic                wait_ok;
  logic                wait_to;
  logic                ivl_hit;
  logic [WORD_SIZE-1:0] rom_op1;
  logic [WORD_SIZE-1:0] rom_op2;
  logic [WORD_SIZE-1:0] rom_add;
  logic [WORD_SIZE-1:0] rom_exp;

  stw_vector_rom #(
    .WORD_SIZE(WORD_SIZE)
  ) u_rom (
    .idx      (vec_idx),
    .op1      (rom_op1),
    .op2      (rom_op2),
    .add      (rom_add),
    .expected (rom_exp)
  );

  assign in_run = (state == LOAD) || (state == START) ||
                  (state == WAIT) || (state == CHECK);
  assign grant_lost = in_run && !stw_grant;
  assign all_done   = &stw_complete_in;
  // First WAIT cycle ignores complete: PEs still show the old run's level.
  assign wait_ok = (state == WAIT) && (wait_cnt != '0) && all_done;
  assign wait_to = (state == WAIT) && !wait_ok && (wait_cnt == WAIT_MAX);
  assign ivl_hit = (INTERVAL != 0) && (state == IDLE) &&
                   (ivl_cnt == IVL_MAX);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (pending) state_nxt = REQ;
      REQ:   if (stw_grant) state_nxt = LOAD;
      LOAD:  state_nxt = START;
      START: state_nxt = WAIT;
      WAIT:  if (wait_ok || wait_to) state_nxt = CHECK;
      CHECK: state_nxt = (vec_idx == LAST_VEC) ? DONE : LOAD;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (grant_lost) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pending   <= 1'b0;
      ivl_cnt   <= '0;
      vec_idx   <= '0;
      wait_cnt  <= '0;
      timeout_q <= 1'b0;
      run_fail  <= '0;
      fault_map <= '0;
      run_count <= '0;
    end else begin
      state     <= state_nxt;
      timeout_q <= wait_to;
      wait_cnt  <= (state == WAIT) ? wait_cnt + 16'd1 : '0;

      // Entering REQ consumes the request; a new test_req re-arms it.
      if (state == IDLE && pending)
        pending <= test_req;
      else
        pending <= pending | test_req | ivl_hit | grant_lost;

      if (INTERVAL != 0 && state == IDLE)
        ivl_cnt <= ivl_hit ? '0 : ivl_cnt + 32'd1;

      if (grant_lost) begin
        vec_idx  <= '0;
        run_fail <= '0;
      end else if (state == CHECK) begin
        run_fail <= run_fail | ~stw_result_in |
                    (timeout_q ? ~stw_complete_in : '0);
        if (vec_idx != LAST_VEC)
          vec_idx <= vec_idx + 2'd1;
      end else if (state == DONE) begin
        vec_idx  <= '0;
        run_fail <= '0;
      end

      if (state == DONE) begin
        fault_map <= (fault_clear ? '0 : fault_map) | run_fail;
        if (run_count != 16'hFFFF)
          run_count <= run_count + 16'd1;
      end else if (fault_clear) begin
        fault_map <= '0;
      end
    end
  end

  assign stw_req      = (state != IDLE);
  assign stw_load_en  = (state == LOAD);
  assign stw_start    = (state == START);
  assign run_done     = (state == DONE);
  assign any_fault    = |fault_map;
  assign stw_mult_op1 = in_run ? rom_op1 : '0;
  assign stw_mult_op2 = in_run ? rom_op2 : '0;
  assign stw_add_op   = in_run ? rom_add : '0;
  assign stw_expected = in_run ? rom_exp : '0;

endmodule
